// File: rtl/vbat_monitor_if.sv
// vbat_monitor_if: request/result handshake between the battery
// monitor (master) and the ADC wrapper (slave).
//   adc_req   : one-cycle conversion request, master -> slave
//   adc_ready : one-cycle result strobe, slave -> master
//   adc_value : 14-bit result, qualified by adc_ready
`timescale 1ns/1ps
interface vbat_monitor_if;
  logic        adc_req;
  logic        adc_ready;
  logic [13:0] adc_value;

  modport master (
    output adc_req,
    input  adc_ready,
    input  adc_value
  );

  modport slave (
    input  adc_req,
    output adc_ready,
    output adc_value
  );
endinterface

// File: rtl/vbat_monitor.sv
// vbat_monitor: periodic ADC sampler, block averager, hysteretic
// low-battery flag and sticky conversion-timeout error.
// Ports: clk, reset_n (async, active low), enable (level),
//   err_clr (pulse), adc (vbat_monitor_if.master),
//   vbat_avg/vbat_valid (published average + strobe),
//   low_batt (hysteretic flag), timeout_err (sticky).
// Optional: define VBAT_MIN_HOLD_EN to add vbat_min, the running
//   minimum of published averages (reset/err_clr -> 14'h3FFF).
`timescale 1ns/1ps
module vbat_monitor #(
  parameter int          SAMPLE_PERIOD = 1000000,
  parameter int          AVG_LOG2      = 3,
  parameter int          TIMEOUT_CYC   = 4096,
  parameter logic [13:0] LOW_THRESH    = 14'd9000,
  parameter logic [13:0] LOW_HYST      = 14'd200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          err_clr,
  vbat_monitor_if.master adc,
  output logic [13:0]   vbat_avg,
  output logic          vbat_valid,
  output logic          low_batt,
  output logic          timeout_err
`ifdef VBAT_MIN_HOLD_EN
  ,
  output logic [13:0]   vbat_min
`endif
);

  localparam int AW = 14 + AVG_LOG2;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [PW-1:0] P_LOAD = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  // Release level, widened so THRESH+HYST cannot wrap.
  localparam logic [14:0] HI_LVL =
    {1'b0, LOW_THRESH} + {1'b0, LOW_HYST};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    GAP
  } state_t;

  state_t              state;
  logic                req_q;
  logic [AW-1:0]       acc;
  logic [AVG_LOG2-1:0] cnt;
  logic [PW-1:0]       pcnt;
  logic [TW-1:0]       tcnt;

  logic [AW-1:0]       sum;
  logic [13:0]         avg_new;
  logic                low_nxt;

  assign adc.adc_req = req_q;

  // Accumulator including the sample arriving this cycle.
  assign sum     = acc + AW'(adc.adc_value);
  assign avg_new = sum[AW-1:AVG_LOG2];

  always_comb begin
    low_nxt = low_batt;
    if ({1'b0, avg_new} >= HI_LVL)
      low_nxt = 1'b0;
    if (avg_new < LOW_THRESH)
      low_nxt = 1'b1;
  end

`ifdef VBAT_MIN_HOLD_EN
  logic [13:0] min_nxt;
  assign min_nxt = (avg_new < vbat_min) ? avg_new : vbat_min;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      vbat_avg    <= '0;
      vbat_valid  <= 1'b0;
      low_batt    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef VBAT_MIN_HOLD_EN
      vbat_min    <= 14'h3FFF;
`endif
    end else begin
      vbat_valid <= 1'b0;
      req_q      <= 1'b0;
      if (err_clr)
        timeout_err <= 1'b0;

      if (!enable) begin
        // Any in-flight request is left alone; its result
        // arrives outside WAIT and is ignored.
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            acc   <= '0;
            cnt   <= '0;
            state <= REQ;
            req_q <= 1'b1;
          end
          REQ: begin
            tcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            tcnt <= tcnt + TW'(1);
            if (adc.adc_ready) begin
              state <= GAP;
              pcnt  <= P_LOAD;
              if (cnt == '1) begin
                vbat_avg   <= avg_new;
                vbat_valid <= 1'b1;
                low_batt   <= low_nxt;
                acc        <= '0;
                cnt        <= '0;
`ifdef VBAT_MIN_HOLD_EN
                vbat_min   <= min_nxt;
`endif
              end else begin
                acc <= sum;
                cnt <= cnt + AVG_LOG2'(1);
              end
            end else if (tcnt == T_LAST) begin
              // Set takes priority over a same-cycle err_clr.
              timeout_err <= 1'b1;
              state       <= GAP;
              pcnt        <= P_LOAD;
            end
          end
          GAP: begin
            if (pcnt == '0) begin
              state <= REQ;
              req_q <= 1'b1;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end

`ifdef VBAT_MIN_HOLD_EN
      if (err_clr)
        vbat_min <= 14'h3FFF;
`endif
    end
  end

endmodule

// File: tb/tb_vbat_monitor.sv
// tb_vbat_monitor: directed bench for vbat_monitor with a small
// ADC responder; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_vbat_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        err_clr;
  logic [13:0] vbat_avg;
  logic        vbat_valid;
  logic        low_batt;
  logic        timeout_err;
`ifdef VBAT_MIN_HOLD_EN
  logic [13:0] vbat_min;
`endif

  vbat_monitor_if bus ();

  vbat_monitor #(
    .SAMPLE_PERIOD (16),
    .AVG_LOG2      (2),
    .TIMEOUT_CYC   (64),
    .LOW_THRESH    (14'd1000),
    .LOW_HYST      (14'd50)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .adc         (bus),
    .vbat_avg    (vbat_avg),
    .vbat_valid  (vbat_valid),
    .low_batt    (low_batt),
    .timeout_err (timeout_err)
`ifdef VBAT_MIN_HOLD_EN
    ,
    .vbat_min    (vbat_min)
`endif
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int nvalid = 0;
  int errs   = 0;
  int checks = 0;
  int last_req = -1;
  bit chk_gap  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset_n === 1'b1 && vbat_valid === 1'b1)
      nvalid <= nvalid + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.adc_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(bus.adc_req), 1);
  endtask

  // Answer the next request 5 cycles later with value v.
  task automatic adc_sample(input logic [13:0] v);
    wait_req();
    if (chk_gap && last_req >= 0)
      chk("req_gap", 32'(cyc - last_req), 22);
    last_req = cyc;
    repeat (5) @(negedge clk);
    bus.adc_ready = 1'b1;
    bus.adc_value = v;
    @(negedge clk);
    bus.adc_ready = 1'b0;
    bus.adc_value = 14'd0;
  endtask

  task automatic inject();
    bus.adc_ready = 1'b1;
    bus.adc_value = 14'h3FFF;
    @(negedge clk);
    bus.adc_ready = 1'b0;
    bus.adc_value = 14'd0;
  endtask

  task automatic avg4(input string tag,
                      input logic [13:0] a, input logic [13:0] b,
                      input logic [13:0] c, input logic [13:0] d,
                      input logic [13:0] ea, input logic el,
                      input bit inj);
    int n0;
    n0 = nvalid;
    adc_sample(a);
    if (inj) inject();
    adc_sample(b);
    adc_sample(c);
    adc_sample(d);
    chk({tag, "_valid"}, 32'(vbat_valid), 1);
    chk({tag, "_avg"}, 32'(vbat_avg), 32'(ea));
    chk({tag, "_low"}, 32'(low_batt), 32'(el));
    @(negedge clk);
    chk({tag, "_vpulse"}, 32'(vbat_valid), 0);
    chk({tag, "_nvalid"}, 32'(nvalid - n0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n0;
    reset_n       = 1'b0;
    enable        = 1'b0;
    err_clr       = 1'b0;
    bus.adc_ready = 1'b0;
    bus.adc_value = 14'd0;
    repeat (3) @(negedge clk);
    chk("rst_avg", 32'(vbat_avg), 0);
    chk("rst_valid", 32'(vbat_valid), 0);
    chk("rst_low", 32'(low_batt), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_req", 32'(bus.adc_req), 0);
`ifdef VBAT_MIN_HOLD_EN
    chk("rst_min", 32'(vbat_min), 32'h3FFF);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(bus.adc_req), 0);

    // Basic 4-sample average and request spacing.
    enable  = 1'b1;
    chk_gap = 1'b1;
    avg4("t1", 14'd1000, 14'd1002, 14'd1004, 14'd1006,
         14'd1003, 1'b0, 1'b0);
    chk_gap = 1'b0;

    // Hysteresis: 1000 set, 1050 release.
    avg4("t2a", 14'd990, 14'd990, 14'd990, 14'd990,
         14'd990, 1'b1, 1'b0);
    avg4("t2b", 14'd1040, 14'd1040, 14'd1040, 14'd1040,
         14'd1040, 1'b1, 1'b0);
    avg4("t2c", 14'd1048, 14'd1049, 14'd1050, 14'd1050,
         14'd1049, 1'b1, 1'b0);
    avg4("t2d", 14'd1050, 14'd1050, 14'd1050, 14'd1050,
         14'd1050, 1'b0, 1'b0);

    // Stray ready during GAP is ignored.
    avg4("t4", 14'd2000, 14'd2000, 14'd2004, 14'd2008,
         14'd2003, 1'b0, 1'b1);

    // Silent ADC -> timeout on 64th WAIT cycle.
    n0 = nvalid;
    wait_req();
    r = cyc;
    repeat (64) @(negedge clk);
    chk("t3_err_early", 32'(timeout_err), 0);
    @(negedge clk);
    chk("t3_err_set", 32'(timeout_err), 1);
    repeat (15) @(negedge clk);
    chk("t3_req_early", 32'(bus.adc_req), 0);
    @(negedge clk);
    chk("t3_req_next", 32'(bus.adc_req), 1);
    chk("t3_req_cyc", 32'(cyc - r), 81);
    chk("t3_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(timeout_err), 0);
    chk("t3_novalid", 32'(nvalid - n0), 0);

    // Disable with outstanding request, stray ready in IDLE.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    inject();
    repeat (2) @(negedge clk);
    chk("t5_idle_req", 32'(bus.adc_req), 0);

    // Partial block dropped by disable.
    enable = 1'b1;
    adc_sample(14'd3000);
    adc_sample(14'd3000);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_hold_avg", 32'(vbat_avg), 2003);
    inject();
    @(negedge clk);
    enable = 1'b1;
    avg4("t5", 14'd500, 14'd500, 14'd500, 14'd504,
         14'd501, 1'b1, 1'b0);

    // Async reset in the middle of WAIT.
    wait_req();
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("ar_avg", 32'(vbat_avg), 0);
    chk("ar_low", 32'(low_batt), 0);
    chk("ar_req", 32'(bus.adc_req), 0);
    chk("ar_valid", 32'(vbat_valid), 0);
    chk("ar_err", 32'(timeout_err), 0);
    @(negedge clk);
    chk("ar_hold_req", 32'(bus.adc_req), 0);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef VBAT_MIN_HOLD_EN
    chk("t6_min_rst", 32'(vbat_min), 32'h3FFF);
    avg4("t6a", 14'd1200, 14'd1200, 14'd1200, 14'd1200,
         14'd1200, 1'b0, 1'b0);
    chk("t6a_min", 32'(vbat_min), 1200);
    avg4("t6b", 14'd1100, 14'd1100, 14'd1100, 14'd1100,
         14'd1100, 1'b0, 1'b0);
    chk("t6b_min", 32'(vbat_min), 1100);
    avg4("t6c", 14'd1150, 14'd1150, 14'd1150, 14'd1150,
         14'd1150, 1'b0, 1'b0);
    chk("t6c_min", 32'(vbat_min), 1100);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_min_clr", 32'(vbat_min), 32'h3FFF);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
